// File: rtl/mmio_timer_pkg.sv
// Shared constants for the memory-mapped interval timer: register offsets,
// TCON bit positions, the default window base and a TCON packing helper.
package mmio_timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    localparam logic [1:0] TH_OFF      = 2'd0;
    localparam logic [1:0] TL_OFF      = 2'd1;
    localparam logic [1:0] TCON_OFF    = 2'd2;
    localparam logic [1:0] SYSTICK_OFF = 2'd3;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic is;
        logic ie;
        logic en;
    } tcon_t;

    function automatic logic [31:0] pack_tcon(input tcon_t tcon);
        return {29'd0, tcon.is, tcon.ie, tcon.en};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider producing one advance pulse every PRESCALE enabled cycles.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic advance
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] count;

    // Divider count: runs 0..PRESCALE-1 while enabled, frozen otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 16'd0;
        end else if (en) begin
            if (count == LAST) begin
                count <= 16'd0;
            end else begin
                count <= count + 16'd1;
            end
        end else begin
            count <= count;
        end
    end

    assign advance = en && (count == LAST);

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped interval timer: TH/TL/TCON/SYSTICK registers on the CPU data
// bus, reload-on-overflow counting, tick pulse and interrupt request.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_rd,
    input  logic        mem_wr,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        tick
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] systick;
    tcon_t       tcon;

    logic       hit;
    logic [1:0] offset;
    logic       wr_th;
    logic       wr_tl;
    logic       wr_tcon;
    logic       advance;
    logic       overflow;
    logic       unused_addr_bits;

    assign hit              = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset           = addr[3:2];
    assign unused_addr_bits = ^addr[1:0];

    assign wr_th   = mem_wr && hit && (offset == TH_OFF);
    assign wr_tl   = mem_wr && hit && (offset == TL_OFF);
    assign wr_tcon = mem_wr && hit && (offset == TCON_OFF);

    timer_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (tcon.en),
        .advance(advance)
    );

    // A CPU store to TL in the same cycle cancels the overflow entirely.
    assign overflow = advance && (tl == TL_MAX) && !wr_tl;

    // Reload and counter registers; TH write lands after this edge's reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            th <= 32'd0;
            tl <= 32'd0;
        end else begin
            th <= wr_th ? wdata : th;
            if (wr_tl) begin
                tl <= wdata;
            end else if (overflow) begin
                tl <= th;
            end else if (advance) begin
                tl <= tl + 32'd1;
            end else begin
                tl <= tl;
            end
        end
    end

    // Control/status: an overflow-set IS is merged with a concurrent TCON store.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcon <= '0;
        end else if (wr_tcon) begin
            tcon.en <= wdata[TCON_EN];
            tcon.ie <= wdata[TCON_IE];
            tcon.is <= wdata[TCON_IS] | (overflow & tcon.ie);
        end else begin
            tcon.en <= tcon.en;
            tcon.ie <= tcon.ie;
            tcon.is <= tcon.is | (overflow & tcon.ie);
        end
    end

    // Free-running cycle counter and the registered tick pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            systick <= 32'd0;
            tick    <= 1'b0;
        end else begin
            systick <= systick + 32'd1;
            tick    <= overflow;
        end
    end

    assign irq = tcon.ie & tcon.is;

    // Zero-latency read mux for the single-cycle CPU.
    always_comb begin
        rdata = 32'd0;
        if (mem_rd && hit) begin
            case (offset)
                TH_OFF:      rdata = th;
                TL_OFF:      rdata = tl;
                TCON_OFF:    rdata = pack_tcon(tcon);
                SYSTICK_OFF: rdata = systick;
                default:     rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench: two timers (PRESCALE 1 and 4) on a shared bus, checked
// every cycle against a register-level reference model plus directed checks.
module tb_mmio_timer;

    localparam logic [31:0] B = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] rdata0, rdata1;
    logic        irq0, irq1, tick0, tick1;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state, index 0 = PRESCALE 1, index 1 = PRESCALE 4
    logic [31:0] m_th [2];
    logic [31:0] m_tl [2];
    logic [31:0] m_sys[2];
    logic        m_en [2];
    logic        m_ie [2];
    logic        m_is [2];
    logic        m_tick[2];
    int unsigned m_pre[2];
    int unsigned presc[2] = '{1, 4};

    logic [31:0] obs0, obs1;
    logic        obs_tick0, obs_irq0;

    always #5 clk = ~clk;

    mmio_timer #(.BASE_ADDR(B), .PRESCALE(1)) dut0 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .rdata(rdata0), .irq(irq0), .tick(tick0)
    );

    mmio_timer #(.BASE_ADDR(B), .PRESCALE(4)) dut1 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .rdata(rdata1), .irq(irq1), .tick(tick1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int k, input logic [1:0] off);
        case (off)
            2'd0:    return m_th[k];
            2'd1:    return m_tl[k];
            2'd2:    return {29'd0, m_is[k], m_ie[k], m_en[k]};
            default: return m_sys[k];
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_th[k] = 32'd0; m_tl[k] = 32'd0; m_sys[k] = 32'd0;
            m_en[k] = 1'b0; m_ie[k] = 1'b0; m_is[k] = 1'b0;
            m_tick[k] = 1'b0; m_pre[k] = 0;
        end
    endtask

    // One bus cycle: drive at negedge, check outputs, then advance the model at posedge.
    task automatic step(input logic rst, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        logic        hit;
        logic [1:0]  off;
        logic [31:0] exp_rd;
        logic        adv, ovf, w_th, w_tl, w_tc;
        @(negedge clk);
        reset = rst; mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
        #1;
        hit = (a[31:4] == B[31:4]);
        off = a[3:2];
        exp_rd = (rd && hit) ? model_read(0, off) : 32'd0;
        check("rdata0", rdata0, exp_rd);
        exp_rd = (rd && hit) ? model_read(1, off) : 32'd0;
        check("rdata1", rdata1, exp_rd);
        check("irq0", 32'(irq0), 32'(m_ie[0] & m_is[0]));
        check("irq1", 32'(irq1), 32'(m_ie[1] & m_is[1]));
        check("tick0", 32'(tick0), 32'(m_tick[0]));
        check("tick1", 32'(tick1), 32'(m_tick[1]));
        obs0 = rdata0; obs1 = rdata1; obs_tick0 = tick0; obs_irq0 = irq0;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            w_th = wr && hit && (off == 2'd0);
            w_tl = wr && hit && (off == 2'd1);
            w_tc = wr && hit && (off == 2'd2);
            for (int k = 0; k < 2; k++) begin
                adv = m_en[k] && (m_pre[k] == presc[k] - 1);
                ovf = adv && (m_tl[k] == 32'hFFFF_FFFF) && !w_tl;
                if (m_en[k]) m_pre[k] = (m_pre[k] + 1) % presc[k];
                if (w_tl)     m_tl[k] = d;
                else if (ovf) m_tl[k] = m_th[k];
                else if (adv) m_tl[k] = m_tl[k] + 32'd1;
                if (w_th) m_th[k] = d;
                if (w_tc) begin
                    m_is[k] = d[2] | (ovf & m_ie[k]);
                    m_en[k] = d[0];
                    m_ie[k] = d[1];
                end else begin
                    m_is[k] = m_is[k] | (ovf & m_ie[k]);
                end
                m_tick[k] = ovf;
                m_sys[k]  = m_sys[k] + 32'd1;
            end
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic bus_read(input logic [31:0] a);
        step(1'b0, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic pulse_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int         nt, ni;
        logic [3:0] pat;
        logic [1:0] off;
        logic [31:0] a, d;
        int unsigned r;

        reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        model_clear();

        // 1. reset state
        bus_read(B);        check("t1_th", obs0, 32'd0);
        bus_read(B + 4);    check("t1_tl", obs0, 32'd0);
        bus_read(B + 8);    check("t1_tcon", obs0, 32'd0);
        check("t1_irq", 32'(obs_irq0), 32'd0);
        check("t1_tick", 32'(obs_tick0), 32'd0);
        bus_read(32'h4000_0010); check("t1_miss", obs0, 32'd0);

        // 2. basic overflow with PRESCALE 1
        bus_write(B, 32'hFFFF_FFFC);
        bus_write(B + 4, 32'hFFFF_FFFE);
        bus_write(B + 8, 32'd3);
        bus_read(B + 4);
        bus_read(B + 4);    check("t2_tl_max", obs0, 32'hFFFF_FFFF);
        bus_read(B + 4);    check("t2_reload", obs0, 32'hFFFF_FFFC);
        check("t2_tick", 32'(obs_tick0), 32'd1);
        check("t2_irq", 32'(obs_irq0), 32'd1);
        pat = 4'd0;
        for (int j = 0; j < 4; j++) begin
            idle(1);
            pat[j] = obs_tick0;
        end
        check("t2_period", 32'(pat), 32'h8);

        // 3. interrupt clear, then IE=0
        bus_write(B + 8, 32'd3);
        bus_read(B + 8);    check("t3_tcon", obs0, 32'd3);
        check("t3_irq", 32'(obs_irq0), 32'd0);
        bus_write(B + 8, 32'd1);
        bus_write(B + 8, 32'd1);
        nt = 0; ni = 0;
        for (int j = 0; j < 8; j++) begin
            idle(1);
            nt += int'(obs_tick0);
            ni += int'(obs_irq0);
        end
        check("t3_ticks", 32'(nt), 32'd2);
        check("t3_noirq", 32'(ni), 32'd0);

        // 4. prescaler (dut1 has PRESCALE 4)
        pulse_reset();
        bus_write(B + 4, 32'd0);
        bus_write(B + 8, 32'd1);
        idle(12);
        bus_read(B + 4);    check("t4_tl_p4", obs1, 32'd3);
        check("t4_tl_p1", obs0, 32'd12);
        bus_write(B + 8, 32'd0);
        idle(10);
        bus_read(B + 4);    check("t4_hold", obs1, 32'd3);

        // 5. collisions
        pulse_reset();
        bus_write(B + 8, 32'd3);
        bus_write(B + 4, 32'hFFFF_FFFF);
        bus_write(B + 4, 32'd5);
        bus_read(B + 4);    check("t5_tl_wins", obs0, 32'd5);
        check("t5_no_tick", 32'(obs_tick0), 32'd0);
        bus_write(B + 4, 32'hFFFF_FFFF);
        bus_write(B + 8, 32'd3);
        bus_read(B + 8);    check("t5_tcon", obs0, 32'd7);
        check("t5_irq", 32'(obs_irq0), 32'd1);

        // 6. mid-run reset and SYSTICK
        pulse_reset();
        bus_write(B + 8, 32'd1);
        idle(100);
        pulse_reset();
        bus_read(B + 12);   check("t6_sys0", obs0, 32'd0);
        bus_write(B + 12, 32'hDEAD_BEEF);
        idle(8);
        bus_read(B + 12);   check("t6_sys10", obs0, 32'd10);
        bus_read(B);        check("t6_th", obs0, 32'd0);
        bus_read(B + 4);    check("t6_tl", obs0, 32'd0);
        bus_read(B + 8);    check("t6_tcon", obs0, 32'd0);
        check("t6_irq", 32'(obs_irq0), 32'd0);

        // randomized traffic, biased toward the overflow boundary
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom_range(0, 199);
            off = 2'($urandom_range(0, 3));
            a   = {B[31:4], off, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) a = $urandom;
            case (off)
                2'd1:    d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - $urandom_range(0, 6) : $urandom;
                2'd2:    d = 32'($urandom_range(0, 7));
                default: d = $urandom;
            endcase
            step(r == 0, $urandom_range(0, 1) == 1, r > 0 && r < 40, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped interval timer on the CPU data bus, next to the RAM/peripheral block.
- The CPU uses ordinary lw/sw to program a reload value, a counter and a control/status register.
- On counter overflow the timer reloads and can raise an interrupt.
- The interrupt request is the irq source the control unit samples to divert the PC to the exception vector, with $26 as the return-address register.

Parameters:
- BASE_ADDR, 32'h4000_0000, word-aligned base of the 16-byte register window.
- PRESCALE, 1, number of clk cycles per counter tick; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  32  byte address from the ALU result; bits [1:0] are ignored.
- wdata  input  32  store data, from register-file port B.
- mem_rd  input  1  read strobe.
- mem_wr  input  1  write strobe.
- rdata  output  32  read data, combinational.
- irq  output  1  interrupt request, registered-state derived.
- tick  output  1  one-cycle pulse on each counter overflow, for debug and LEDs.

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0x0 TH: reload value, R/W.
  - 0x4 TL: counter, R/W.
  - 0x8 TCON: bit0 EN, bit1 IE, bit2 IS; bits [31:3] read as 0.
  - 0xC SYSTICK: free-running 32-bit cycle count, read-only; writes are ignored.
- Address decode:
  - A hit requires addr[31:4] == BASE_ADDR[31:4].
  - Offset is addr[3:2].
  - Addresses outside the window are ignored for writes.
- Reset (synchronous, active-high): TH=0, TL=0, TCON=0, SYSTICK=0, prescaler=0; outputs irq=0, tick=0.
- Reset asserted mid-count clears everything at that edge; no pending tick survives.
- Reads:
  - rdata = selected register when mem_rd && hit, else 32'h0.
  - Zero latency, because the CPU is single-cycle.
  - Reads have no side effects.
- Writes: take effect at the clk edge where mem_wr && hit; the new value is visible on rdata the following cycle.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN=1.
  - Asserts an internal advance on the cycle its count equals PRESCALE-1, then wraps to 0.
  - Holds its value while EN=0.
  - With PRESCALE=1, advance = EN every cycle.
- Counter, on advance:
  - If TL == 32'hFFFF_FFFF: TL <= TH, tick=1 for that cycle, and IS <= 1 only if IE=1.
  - Otherwise TL <= TL+1, with 32-bit wrap via the reload path only.
- SYSTICK increments every cycle regardless of EN and wraps naturally at 2^32.
- irq = IE & IS, driven from registers (no combinational path from the bus).
- IS is cleared only by a software write of 0 to TCON bit2; writing 1 to bit2 sets it, for software test.
- Simultaneous events in the same cycle:
  - CPU write to TL and an advance: the CPU write wins and the tick is lost; tick stays 0 in that cycle.
  - CPU write to TH and an overflow: the reload uses the old TH; the new TH applies from the next overflow.
  - CPU write to TCON and an overflow with IE set: EN and IE take the written values; IS <= written bit2 OR overflow-set, so the interrupt is not lost.
  - Writing EN=0 in the same cycle as an advance: the advance still completes this edge.
- mem_rd and mem_wr both high is legal: rdata shows the pre-write value.
- The ISR clearing IS drops irq on the next cycle.

Decomposition:
- Shared package holds:
  - register offset constants (TH_OFF, TL_OFF, TCON_OFF, SYSTICK_OFF);
  - TCON bit positions (TCON_EN, TCON_IE, TCON_IS);
  - the default peripheral base address.
- One natural sub-module: timer_prescaler.
  - Inputs: clk, reset, en.
  - Output: advance pulse.
  - Parameter: PRESCALE.
- Decode, register file and read mux stay in mmio_timer.

Test Plan:
1. Reset then read: reset=1 for 2 cycles, then read 0x0/0x4/0x8 -> rdata=0 each, irq=0, tick=0; a read at 0x4000_0010 -> rdata=0.
2. Basic overflow, PRESCALE=1:
   - Stimulus: write TH=FFFF_FFFC, TL=FFFF_FFFE, TCON=3.
   - Required: TL reads FFFF_FFFF after one cycle.
   - Required on the next advance: TL=FFFF_FFFC, tick=1 for exactly 1 cycle, IS=1, irq=1 the following cycle.
   - Required: next overflow occurs 4 cycles later.
3. Interrupt clear:
   - Stimulus: with irq=1, write TCON=3.
   - Required: irq=0 next cycle, TCON reads 3, counting continues.
   - Stimulus: then write TCON=1 (IE=0).
   - Required: overflows pulse tick but IS stays 0.
4. Prescaler, PRESCALE=4:
   - Stimulus: TL=0, TCON=1.
   - Required: after 12 cycles TL=3.
   - Stimulus: write TCON=0 and wait 10 cycles.
   - Required: TL unchanged.
5. Collisions:
   - Stimulus: write TL=5 in the overflow cycle.
   - Required: TL=5, tick=0.
   - Stimulus: write TCON=3 in an overflow cycle with IE=1.
   - Required: TCON reads 7, irq=1.
6. Mid-run reset and SYSTICK:
   - Stimulus: run 100 cycles with EN=1, assert reset for 1 cycle.
   - Required: all registers 0, irq=0.
   - Required: SYSTICK reads N after N cycles post-reset; a write to 0xC is ignored.
